// File: rtl/i2c_slv_pkg.sv
// Shared types and bus constants for the I2C register-file target.
package i2c_slv_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StSubAddr,
        StSubAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } i2c_state_e;

    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_slv_line_det.sv
// SCL/SDA synchronisers and bus-condition detection (edges, START, STOP).
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronisers.
module i2c_slv_line_det
    import i2c_slv_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda_s
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl_ln;
    logic       w_sda_ln;
    logic       r_scl_prev;
    logic       r_sda_prev;

    // Idle bus is high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_flt;
    logic       r_sda_flt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_flt  <= 1'b1;
            r_sda_flt  <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_flt  <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
            r_sda_flt  <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
        end
    end

    assign w_scl_ln = r_scl_flt;
    assign w_sda_ln = r_sda_flt;
`else
    assign w_scl_ln = r_scl_sync[1];
    assign w_sda_ln = r_sda_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl_ln;
            r_sda_prev <= w_sda_ln;
        end
    end

    assign o_scl_rise  = w_scl_ln & ~r_scl_prev;
    assign o_scl_fall  = ~w_scl_ln & r_scl_prev;
    assign o_start_det = r_sda_prev & ~w_sda_ln & w_scl_ln & r_scl_prev;
    assign o_stop_det  = ~r_sda_prev & w_sda_ln & w_scl_ln & r_scl_prev;
    assign o_sda_s     = w_sda_ln;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing an 8-bit-addressed register file; SCL is input only (no stretching).
module i2c_slave_regfile
    import i2c_slv_pkg::*;
#(
    parameter logic [6:0]  SLA_ADDR = 7'h39,
    parameter int unsigned NUM_REGS = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic [7:0] i_loc_addr,
    output logic [7:0] o_loc_data,
    output logic       o_busy
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    i2c_state_e r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack_seen, w_ack_seen_nxt;
    logic       r_sda_drv, w_sda_drv_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_wr_valid, w_wr_valid_nxt;
    logic [7:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic [7:0] r_loc_data;
    logic       w_mem_we;

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start_det;
    logic       w_stop_det;
    logic       w_sda_s;
    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_byte;
    logic       w_ptr_ok;
    logic       w_loc_ok;

    logic [7:0] r_mem [NUM_REGS];

    i2c_slv_line_det u_line_det (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scl       (i_scl),
        .i_sda       (io_sda),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det),
        .o_sda_s     (w_sda_s)
    );

    // Sub-addresses beyond the implemented range read as 0xFF and drop writes.
    if (NUM_REGS >= 256) begin : g_full_map
        assign w_ptr_ok = 1'b1;
        assign w_loc_ok = 1'b1;
    end else begin : g_part_map
        assign w_ptr_ok = (r_ptr < 8'(NUM_REGS));
        assign w_loc_ok = (i_loc_addr < 8'(NUM_REGS));
    end

    assign w_rx_byte = {r_shift[6:0], w_sda_s};
    assign w_rd_byte = w_ptr_ok ? r_mem[r_ptr[AW-1:0]] : 8'hFF;

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_ptr_nxt      = r_ptr;
        w_rw_nxt       = r_rw;
        w_ack_seen_nxt = r_ack_seen;
        w_sda_drv_nxt  = r_sda_drv;
        w_busy_nxt     = r_busy;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_mem_we       = 1'b0;

        if (w_stop_det) begin
            w_state_nxt    = StIdle;
            w_bit_cnt_nxt  = 3'd0;
            w_ack_seen_nxt = 1'b0;
            w_sda_drv_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
        end else if (w_start_det) begin
            w_state_nxt    = StDevAddr;
            w_bit_cnt_nxt  = 3'd0;
            w_ack_seen_nxt = 1'b0;
            w_sda_drv_nxt  = 1'b0;
            w_busy_nxt     = 1'b1;
        end else begin
            unique case (r_state)
                StDevAddr, StSubAddr, StWrData: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_shift_nxt   = w_rx_byte;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == StDevAddr) begin
                                if (w_rx_byte[7:1] == SLA_ADDR) begin
                                    w_state_nxt = StDevAck;
                                    w_rw_nxt    = w_rx_byte[0];
                                end else begin
                                    w_state_nxt = StIgnore;
                                end
                            end else if (r_state == StSubAddr) begin
                                w_ptr_nxt   = w_rx_byte;
                                w_state_nxt = StSubAck;
                            end else begin
                                w_mem_we       = w_ptr_ok;
                                w_wr_valid_nxt = 1'b1;
                                w_wr_addr_nxt  = r_ptr;
                                w_wr_data_nxt  = w_rx_byte;
                                w_ptr_nxt      = r_ptr + 8'd1;
                                w_state_nxt    = StWrAck;
                            end
                        end
                    end
                end
                // First SCL fall after the 8th bit starts the ACK, the next one ends it.
                StDevAck, StSubAck, StWrAck: begin
                    if (w_scl_rise) begin
                        w_ack_seen_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        if (!r_ack_seen) begin
                            w_sda_drv_nxt = (ACK == 1'b0);
                        end else begin
                            w_sda_drv_nxt  = 1'b0;
                            w_ack_seen_nxt = 1'b0;
                            w_bit_cnt_nxt  = 3'd0;
                            if (r_state == StDevAck && r_rw == I2C_RW_READ) begin
                                w_state_nxt   = StRdData;
                                w_shift_nxt   = w_rd_byte;
                                w_sda_drv_nxt = ~w_rd_byte[7];
                            end else if (r_state == StDevAck) begin
                                w_state_nxt = StSubAddr;
                            end else begin
                                w_state_nxt = StWrData;
                            end
                        end
                    end
                end
                StRdData: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = StRdAck;
                        end
                    end else if (w_scl_fall) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_sda_drv_nxt = ~r_shift[6];
                    end
                end
                StRdAck: begin
                    if (w_scl_rise) begin
                        if (w_sda_s == ACK) begin
                            w_ack_seen_nxt = 1'b1;
                            w_ptr_nxt      = r_ptr + 8'd1;
                        end else begin
                            w_state_nxt = StIgnore;
                        end
                    end else if (w_scl_fall) begin
                        if (!r_ack_seen) begin
                            w_sda_drv_nxt = 1'b0;
                        end else begin
                            w_ack_seen_nxt = 1'b0;
                            w_bit_cnt_nxt  = 3'd0;
                            w_shift_nxt    = w_rd_byte;
                            w_sda_drv_nxt  = ~w_rd_byte[7];
                            w_state_nxt    = StRdData;
                        end
                    end
                end
                StIdle, StIgnore: begin
                    w_sda_drv_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt   = StIdle;
                    w_sda_drv_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_ptr      <= 8'd0;
            r_rw       <= 1'b0;
            r_ack_seen <= 1'b0;
            r_sda_drv  <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rw       <= w_rw_nxt;
            r_ack_seen <= w_ack_seen_nxt;
            r_sda_drv  <= w_sda_drv_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[r_ptr[AW-1:0]] <= w_rx_byte;
        end
    end

    // Registered read sees the pre-write value when a bus write lands in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_loc_data <= 8'd0;
        end else begin
            r_loc_data <= w_loc_ok ? r_mem[i_loc_addr[AW-1:0]] : 8'hFF;
        end
    end

    // Reset releases the line combinationally so the bus is freed in the reset cycle.
    assign io_sda     = (r_sda_drv && !i_rst) ? 1'b0 : 1'bz;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_loc_data = r_loc_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: I2C master BFM with pull-up driving two targets on one bus.
module tb_i2c_slave_regfile;

    localparam int Q = 2500;  // quarter SCL period; clk period 84 -> ~120 clk per SCL

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;

    logic       wr_valid1, busy1, wr_valid2, busy2;
    logic [7:0] wr_addr1, wr_data1, loc_data1, wr_addr2, wr_data2, loc_data2;
    logic [7:0] loc_addr1 = 8'd0;
    logic [7:0] loc_addr2 = 8'd0;

    int total = 0;
    int bad = 0;
    int wr_cnt1 = 0;
    int wr_cnt2 = 0;
    logic [7:0] last_addr1 = 8'd0;
    logic [7:0] last_data1 = 8'd0;
    logic [7:0] loc_at_wr1 = 8'd0;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #42 clk = ~clk;

    i2c_slave_regfile #(.SLA_ADDR(7'h39), .NUM_REGS(256)) u_dut1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .io_sda     (sda),
        .o_wr_valid (wr_valid1),
        .o_wr_addr  (wr_addr1),
        .o_wr_data  (wr_data1),
        .i_loc_addr (loc_addr1),
        .o_loc_data (loc_data1),
        .o_busy     (busy1)
    );

    i2c_slave_regfile #(.SLA_ADDR(7'h50), .NUM_REGS(16)) u_dut2 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .io_sda     (sda),
        .o_wr_valid (wr_valid2),
        .o_wr_addr  (wr_addr2),
        .o_wr_data  (wr_data2),
        .i_loc_addr (loc_addr2),
        .o_loc_data (loc_data2),
        .o_busy     (busy2)
    );

    always @(negedge clk) begin
        if (wr_valid1) begin
            wr_cnt1    <= wr_cnt1 + 1;
            last_addr1 <= wr_addr1;
            last_data1 <= wr_data1;
            loc_at_wr1 <= loc_data1;
        end
        if (wr_valid2) wr_cnt2 <= wr_cnt2 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; #Q;
            scl = 1'b1;        #(2*Q);
            scl = 1'b0;        #Q;
        end
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        ack = sda;        #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        b = 8'd0;
        m_sda_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #Q; scl = 1'b1;
            #Q; b = {b[6:0], sda};
            #Q; scl = 1'b0;
            #Q;
        end
        m_sda_low = ~nack; #Q;
        scl = 1'b1;        #(2*Q);
        scl = 1'b0;        #Q;
        m_sda_low = 1'b0;
    endtask

    task automatic loc_rd1(input logic [7:0] a, output logic [7:0] d);
        loc_addr1 = a;
        @(negedge clk);
        @(negedge clk);
        d = loc_data1;
    endtask

    task automatic loc_rd2(input logic [7:0] a, output logic [7:0] d);
        loc_addr2 = a;
        @(negedge clk);
        @(negedge clk);
        d = loc_data2;
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] sub, input logic [7:0] data,
                            output logic [2:0] acks);
        i2c_start();
        write_byte(dev, acks[2]);
        write_byte(sub, acks[1]);
        write_byte(data, acks[0]);
        i2c_stop();
    endtask

    typedef struct {
        logic [7:0] sub;
        logic [7:0] data;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_loc;
    } wr_vec_t;

    wr_vec_t    vecs [3];
    logic [2:0] acks;
    logic       a0, a1, a2, a3;
    logic [7:0] d, r0, r1, r2;
    int         c0;

    initial begin
        vecs[0] = '{sub: 8'h15, data: 8'h5A, exp_addr: 8'h15, exp_data: 8'h5A, exp_loc: 8'h5A};
        vecs[1] = '{sub: 8'h00, data: 8'hA5, exp_addr: 8'h00, exp_data: 8'hA5, exp_loc: 8'hA5};
        vecs[2] = '{sub: 8'h80, data: 8'h3C, exp_addr: 8'h80, exp_data: 8'h3C, exp_loc: 8'h3C};

        // Reset state
        repeat (6) @(negedge clk);
        check("rst_wr_valid", {31'd0, wr_valid1}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr1}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data1}, 32'd0);
        check("rst_loc_data", {24'd0, loc_data1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_sda", {31'd0, sda}, 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single-register writes from the table
        for (int v = 0; v < 3; v++) begin
            c0 = wr_cnt1;
            i2c_start();
            check("tbl_busy_start", {31'd0, busy1}, 32'd1);
            write_byte(8'h72, a0);
            write_byte(vecs[v].sub, a1);
            write_byte(vecs[v].data, a2);
            i2c_stop();
            check("tbl_acks", {29'd0, a0, a1, a2}, 32'd0);
            check("tbl_busy_stop", {31'd0, busy1}, 32'd0);
            check("tbl_wr_count", wr_cnt1 - c0, 32'd1);
            check("tbl_wr_addr", {24'd0, last_addr1}, {24'd0, vecs[v].exp_addr});
            check("tbl_wr_data", {24'd0, last_data1}, {24'd0, vecs[v].exp_data});
            loc_rd1(vecs[v].sub, d);
            check("tbl_loc_data", {24'd0, d}, {24'd0, vecs[v].exp_loc});
        end

        // Local read of the register being written returns the old value that cycle
        loc_addr1 = 8'h15;
        do_write(8'h72, 8'h15, 8'h77, acks);
        check("coll_acks", {29'd0, acks}, 32'd0);
        check("coll_old_value", {24'd0, loc_at_wr1}, 32'h5A);
        loc_rd1(8'h15, d);
        check("coll_new_value", {24'd0, d}, 32'h77);

        // Burst write with sub-address wrap
        c0 = wr_cnt1;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'hFE, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        check("burst_acks_a", {28'd0, a0, a1, a2, a3}, 32'd0);
        write_byte(8'h33, a0);
        i2c_stop();
        check("burst_ack_b", {31'd0, a0}, 32'd0);
        check("burst_wr_count", wr_cnt1 - c0, 32'd3);
        check("burst_last_addr", {24'd0, last_addr1}, 32'h00);
        loc_rd1(8'hFE, d);
        check("burst_mem_fe", {24'd0, d}, 32'h11);
        loc_rd1(8'hFF, d);
        check("burst_mem_ff", {24'd0, d}, 32'h22);
        loc_rd1(8'h00, d);
        check("burst_mem_00", {24'd0, d}, 32'h33);

        // Combined-format read with repeated START
        c0 = wr_cnt1;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'hFE, a1);
        i2c_start();
        write_byte(8'h73, a2);
        check("rd_acks", {29'd0, a0, a1, a2}, 32'd0);
        read_byte(r0, 1'b0);
        read_byte(r1, 1'b0);
        read_byte(r2, 1'b1);
        #Q;
        check("rd_sda_released", {31'd0, sda}, 32'd1);
        i2c_stop();
        check("rd_byte0", {24'd0, r0}, 32'h11);
        check("rd_byte1", {24'd0, r1}, 32'h22);
        check("rd_byte2", {24'd0, r2}, 32'h33);
        check("rd_no_write", wr_cnt1 - c0, 32'd0);

        // Address that matches neither target
        c0 = wr_cnt1;
        i2c_start();
        check("nack_busy_start", {31'd0, busy1}, 32'd1);
        write_byte(8'h74, a0);
        write_byte(8'h15, a1);
        write_byte(8'h00, a2);
        check("nack_all_released", {29'd0, a0, a1, a2}, 32'h7);
        check("nack_busy_mid", {31'd0, busy1}, 32'd1);
        i2c_stop();
        check("nack_busy_stop", {31'd0, busy1}, 32'd0);
        check("nack_no_write", wr_cnt1 - c0, 32'd0);
        loc_rd1(8'h15, d);
        check("nack_mem_kept", {24'd0, d}, 32'h77);

        // STOP after 4 data bits, then a full write to 0x20
        c0 = wr_cnt1;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h20, a1);
        for (int i = 0; i < 4; i++) begin
            m_sda_low = i[0]; #Q;
            scl = 1'b1;       #(2*Q);
            scl = 1'b0;       #Q;
        end
        i2c_stop();
        check("part_acks", {30'd0, a0, a1}, 32'd0);
        check("part_no_write", wr_cnt1 - c0, 32'd0);
        check("part_busy", {31'd0, busy1}, 32'd0);
        do_write(8'h72, 8'h20, 8'h9C, acks);
        check("part_next_acks", {29'd0, acks}, 32'd0);
        check("part_next_count", wr_cnt1 - c0, 32'd1);
        check("part_next_addr", {24'd0, last_addr1}, 32'h20);
        loc_rd1(8'h20, d);
        check("part_next_mem", {24'd0, d}, 32'h9C);

        // Small map (16 registers) on the second target
        do_write(8'hA0, 8'h00, 8'h12, acks);
        check("small_w0_acks", {29'd0, acks}, 32'd0);
        c0 = wr_cnt2;
        do_write(8'hA0, 8'h20, 8'h55, acks);
        check("small_oor_acks", {29'd0, acks}, 32'd0);
        check("small_oor_pulse", wr_cnt2 - c0, 32'd1);
        loc_rd2(8'h00, d);
        check("small_mem0_kept", {24'd0, d}, 32'h12);
        loc_rd2(8'h20, d);
        check("small_loc_oor", {24'd0, d}, 32'hFF);
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h20, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(r0, 1'b1);
        i2c_stop();
        check("small_rd_acks", {29'd0, a0, a1, a2}, 32'd0);
        check("small_rd_oor", {24'd0, r0}, 32'hFF);

        // Reset while the target holds SDA low during a read bit
        do_write(8'hA0, 8'h05, 8'h00, acks);
        check("rst_prep_acks", {29'd0, acks}, 32'd0);
        c0 = wr_cnt2;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h05, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        check("rst_rd_acks", {29'd0, a0, a1, a2}, 32'd0);
        check("rst_rd_driving", {31'd0, sda}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rd_released", {31'd0, sda}, 32'd1);
        repeat (3) @(negedge clk);
        check("rst_rd_busy", {31'd0, busy2}, 32'd0);
        check("rst_rd_no_write", wr_cnt2 - c0, 32'd0);
        rst = 1'b0;
        i2c_stop();
        loc_rd1(8'h15, d);
        check("rst_mem_retained", {24'd0, d}, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
